// File: rtl/prio_grant_unit.sv
// Fixed/round-robin priority arbiter with a registered, held grant.
// A grant stays presented until the consumer accepts it; a new winner can be captured on the same edge.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | no grant presented, outputs zero, waiting for any request
// HOLD  | grant/grant_idx presented and stable until grant_ready
module prio_grant_unit #(
  parameter int N  = 8,
  parameter int IW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          mode,
  input  logic          grant_ready,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          grant_valid
);

  localparam logic IDLE = 1'b0;
  localparam logic HOLD = 1'b1;

  logic          state;
  logic          held_mode;
  logic [IW-1:0] ptr;
  logic [IW-1:0] ptr_upd;
  logic [IW-1:0] start_idx;
  logic [N-1:0]  req_hi;
  logic [N-1:0]  rr_vec;
  logic [IW-1:0] rr_idx;
  logic [IW-1:0] fix_idx;
  logic [IW-1:0] win_idx;
  logic [N-1:0]  win_oh;
  logic          accept;
  logic          advance;

  assign grant_valid = (state == HOLD);
  assign accept      = grant_valid & grant_ready;
  assign advance     = ~grant_valid | grant_ready;

  // The search after an accepted round-robin grant must already see the new pointer.
  assign ptr_upd   = (accept && held_mode) ? grant_idx : ptr;
  assign start_idx = (ptr_upd == IW'(N - 1)) ? '0 : ptr_upd + 1'b1;

  // Requests at or above the start index win first; otherwise wrap to the lowest set bit.
  assign req_hi = req & ({N{1'b1}} << start_idx);
  assign rr_vec = (req_hi != '0) ? req_hi : req;

  always_comb begin
    rr_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rr_vec[k]) rr_idx = IW'(k);
    end
  end

  always_comb begin
    fix_idx = '0;
    for (int k = 0; k < N; k++) begin
      if (req[k]) fix_idx = IW'(k);
    end
  end

  assign win_idx = mode ? rr_idx : fix_idx;
  assign win_oh  = {{(N-1){1'b0}}, 1'b1} << win_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      grant     <= '0;
      grant_idx <= '0;
      held_mode <= 1'b0;
      ptr       <= IW'(N - 1);
    end else begin
      ptr <= ptr_upd;
      if (advance) begin
        if (req != '0) begin
          state     <= HOLD;
          grant     <= win_oh;
          grant_idx <= win_idx;
          held_mode <= mode;
        end else begin
          state     <= IDLE;
          grant     <= '0;
          grant_idx <= '0;
          held_mode <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_prio_grant_unit.sv
// Bench for prio_grant_unit: directed vector table, async-reset sequence, random run vs a reference model.
// A second instance with N=5 exercises the non-power-of-two wrap.
module tb_prio_grant_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic       mode;
  logic       rdy;

  logic [7:0] grant8;
  logic [2:0] idx8;
  logic       valid8;
  logic [4:0] grant5;
  logic [2:0] idx5;
  logic       valid5;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  prio_grant_unit #(.N(8), .IW(3)) dut8 (
    .clk(clk), .rst_n(rst_n), .req(req), .mode(mode), .grant_ready(rdy),
    .grant(grant8), .grant_idx(idx8), .grant_valid(valid8)
  );

  prio_grant_unit #(.N(5), .IW(3)) dut5 (
    .clk(clk), .rst_n(rst_n), .req(req[4:0]), .mode(mode), .grant_ready(rdy),
    .grant(grant5), .grant_idx(idx5), .grant_valid(valid5)
  );

  // Reference model state, index 0 = N=8 instance, 1 = N=5 instance.
  int nn[2] = '{8, 5};
  int m_ptr[2];
  int m_idx[2];
  bit m_valid[2];
  bit m_mode[2];

  typedef struct {
    logic [7:0] req;
    logic       mode;
    logic       rdy;
    logic       ev;
    int         ei;
  } vec_t;

  vec_t tv[$];

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int fixed_ref(input logic [7:0] r);
    int w;
    logic [7:0] x;
    w = 0;
    x = r;
    while (x > 8'd1) begin
      x = x >> 1;
      w++;
    end
    return w;
  endfunction

  function automatic int rr_ref(input logic [7:0] r, input int p, input int n);
    int s;
    int k;
    logic [63:0] x;
    logic [63:0] rot;
    s   = (p + 1) % n;
    x   = {56'd0, r};
    rot = ((x >> s) | (x << (n - s))) & ((64'd1 << n) - 64'd1);
    k   = 0;
    while (rot[k] == 1'b0) k++;
    return (s + k) % n;
  endfunction

  function automatic void model_reset();
    for (int u = 0; u < 2; u++) begin
      m_ptr[u]   = nn[u] - 1;
      m_idx[u]   = 0;
      m_valid[u] = 1'b0;
      m_mode[u]  = 1'b0;
    end
  endfunction

  function automatic void model_step(input int u, input logic [7:0] r, input logic md, input logic rd);
    logic [7:0] rq;
    rq = r & 8'((1 << nn[u]) - 1);
    if (!m_valid[u] || rd) begin
      if (m_valid[u] && rd && m_mode[u]) m_ptr[u] = m_idx[u];
      if (rq != 8'd0) begin
        m_valid[u] = 1'b1;
        m_mode[u]  = md;
        m_idx[u]   = md ? rr_ref(rq, m_ptr[u], nn[u]) : fixed_ref(rq);
      end else begin
        m_valid[u] = 1'b0;
        m_mode[u]  = 1'b0;
        m_idx[u]   = 0;
      end
    end
  endfunction

  task automatic check_model(input string tag);
    cmp({tag, " valid8"}, 32'(valid8), 32'(m_valid[0]));
    cmp({tag, " idx8"},   32'(idx8),   32'(m_idx[0]));
    cmp({tag, " grant8"}, 32'(grant8), m_valid[0] ? (32'd1 << m_idx[0]) : 32'd0);
    cmp({tag, " valid5"}, 32'(valid5), 32'(m_valid[1]));
    cmp({tag, " idx5"},   32'(idx5),   32'(m_idx[1]));
    cmp({tag, " grant5"}, 32'(grant5), m_valid[1] ? (32'd1 << m_idx[1]) : 32'd0);
  endtask

  task automatic check_zero(input string tag);
    cmp({tag, " valid8"}, 32'(valid8), 32'd0);
    cmp({tag, " idx8"},   32'(idx8),   32'd0);
    cmp({tag, " grant8"}, 32'(grant8), 32'd0);
    cmp({tag, " valid5"}, 32'(valid5), 32'd0);
    cmp({tag, " grant5"}, 32'(grant5), 32'd0);
  endtask

  task automatic step(input logic [7:0] r, input logic md, input logic rd, input string tag);
    req  = r;
    mode = md;
    rdy  = rd;
    @(posedge clk);
    model_step(0, r, md, rd);
    model_step(1, r, md, rd);
    #1;
    check_model(tag);
  endtask

  function automatic void add(input logic [7:0] r, input logic md, input logic rd,
                              input logic ev, input int ei);
    vec_t v;
    v.req = r; v.mode = md; v.rdy = rd; v.ev = ev; v.ei = ei;
    tv.push_back(v);
  endfunction

  initial begin
    rst_n = 1'b0;
    req   = '0;
    mode  = 1'b0;
    rdy   = 1'b0;
    model_reset();

    // Fixed priority, repeated every cycle while held.
    repeat (3) add(8'b0010_0110, 1'b0, 1'b1, 1'b1, 5);
    // Round-robin sweep from reset pointer.
    for (int i = 0; i < 8; i++) add(8'hFF, 1'b1, 1'b1, 1'b1, i);
    add(8'hFF, 1'b1, 1'b1, 1'b1, 0);
    // Held grant while not ready, then 7, then 0.
    repeat (4) add(8'b1000_0001, 1'b1, 1'b0, 1'b1, 0);
    add(8'b1000_0001, 1'b1, 1'b1, 1'b1, 7);
    add(8'b1000_0001, 1'b1, 1'b1, 1'b1, 0);
    // Held idx 3 survives req dropping; accept returns to idle; ready while idle is inert.
    add(8'b0000_1000, 1'b1, 1'b1, 1'b1, 3);
    add(8'h00, 1'b1, 1'b0, 1'b1, 3);
    add(8'h00, 1'b1, 1'b0, 1'b1, 3);
    add(8'h00, 1'b1, 1'b1, 1'b0, 0);
    add(8'h00, 1'b1, 1'b1, 1'b0, 0);
    // Wrap-around capture, mode change during hold, fixed grants leave ptr alone.
    add(8'b0000_0100, 1'b1, 1'b0, 1'b1, 2);
    add(8'b1000_0100, 1'b0, 1'b0, 1'b1, 2);
    add(8'b1000_0100, 1'b0, 1'b0, 1'b1, 2);
    add(8'b1000_0100, 1'b0, 1'b1, 1'b1, 7);
    add(8'b1000_0100, 1'b0, 1'b1, 1'b1, 7);
    add(8'b1000_0100, 1'b1, 1'b1, 1'b1, 7);
    add(8'b1000_0100, 1'b1, 1'b1, 1'b1, 2);
    add(8'h00, 1'b1, 1'b1, 1'b0, 0);

    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;

    foreach (tv[i]) begin
      step(tv[i].req, tv[i].mode, tv[i].rdy, $sformatf("vec%0d", i));
      cmp($sformatf("vec%0d tbl_valid", i), 32'(valid8), 32'(tv[i].ev));
      cmp($sformatf("vec%0d tbl_idx", i), 32'(idx8), 32'(tv[i].ei));
      cmp($sformatf("vec%0d tbl_grant", i), 32'(grant8),
          tv[i].ev ? (32'd1 << tv[i].ei) : 32'd0);
    end

    // Async reset mid-hold, held through an edge, then first round-robin grant is 0.
    step(8'b0100_0000, 1'b1, 1'b0, "pre_rst");
    cmp("pre_rst idx", 32'(idx8), 32'd6);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_zero("async_rst");
    req  = 8'hFF;
    mode = 1'b1;
    rdy  = 1'b1;
    @(posedge clk);
    #1;
    check_zero("rst_held");
    rst_n = 1'b1;
    step(8'hFF, 1'b1, 1'b1, "post_rst");
    cmp("post_rst idx", 32'(idx8), 32'd0);
    cmp("post_rst valid", 32'(valid8), 32'd1);

    for (int i = 0; i < 3000; i++) begin
      logic [7:0] r;
      case ($urandom_range(0, 3))
        0:       r = 8'h00;
        1:       r = 8'd1 << $urandom_range(0, 7);
        default: r = 8'($urandom);
      endcase
      step(r, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/prio_grant_unit.md
PRIO_GRANT_UNIT -- requirements
Module: prio_grant_unit

Interface
REQ-001 Parameter N, default 8: number of request lines; legal range 2..32.
REQ-002 Parameter IW, default 3: index width; SHALL equal ceil(log2(N)).
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 req  input  N  request lines; bit k = requester k.
REQ-006 mode  input  1  arbitration mode: 0 = fixed priority, 1 = round-robin.
REQ-007 grant_ready  input  1  consumer accepts the presented grant.
REQ-008 grant  output  N  registered one-hot grant; all zero when grant_valid=0.
REQ-009 grant_idx  output  IW  registered binary index of the granted bit; 0 when grant_valid=0.
REQ-010 grant_valid  output  1  grant/grant_idx hold a grant not yet accepted.

Function
REQ-011 The block SHALL have two states: IDLE (grant_valid=0) and HOLD (grant_valid=1).
REQ-012 In IDLE with req!=0, the block SHALL capture the winner on the next rising edge and enter HOLD; latency from req sampled to grant_valid=1 is exactly 1 cycle.
REQ-013 In IDLE with req==0, the block SHALL stay in IDLE with all outputs zero.
REQ-014 Fixed mode: the winner SHALL be the highest set index of req.
REQ-015 Round-robin mode: the search SHALL start at index (ptr+1) mod N, ascending with wrap-around; the first set bit wins.
REQ-016 ptr (IW bits) SHALL update to grant_idx only on an accepted round-robin grant (grant_valid & grant_ready & the grant was issued with mode=1); fixed-mode grants SHALL leave ptr unchanged.
REQ-017 mode SHALL be sampled only in the cycle a winner is captured; a mode change while in HOLD SHALL not alter the held grant.
REQ-018 In HOLD, grant and grant_idx SHALL remain stable until accepted, even if req changes or the granted bit deasserts.
REQ-019 Acceptance SHALL occur on a rising edge with grant_valid=1 and grant_ready=1.
REQ-020 On acceptance with req!=0 in that cycle, the block SHALL capture a new winner in the same edge (using the updated ptr in round-robin mode) and stay in HOLD; back-to-back grants SHALL therefore be issued every cycle.
REQ-021 On acceptance with req==0, the block SHALL return to IDLE and clear grant and grant_idx.
REQ-022 grant_ready while grant_valid=0 SHALL have no effect.
REQ-023 grant SHALL always equal the one-hot decode of grant_idx whenever grant_valid=1.
REQ-024 For N not a power of two, indices >= N SHALL never be produced; the round-robin wrap SHALL go from N-1 to 0.

Reset
REQ-025 While rst_n=0: grant=0, grant_idx=0, grant_valid=0, state=IDLE, ptr=N-1 (so the first round-robin search starts at index 0).
REQ-026 Reset assertion mid-HOLD SHALL clear all outputs immediately, without waiting for a clock edge; the pending grant is discarded.
REQ-027 After rst_n deasserts, the first capture SHALL occur no earlier than the first rising edge at which rst_n is sampled high.

Verification (N=8)
REQ-028 Fixed mode, req=8'b0010_0110, grant_ready=1 -> after 1 cycle grant=8'b0010_0000, grant_idx=5, grant_valid=1; this grant repeats every cycle while req is held.
REQ-029 Round-robin, out of reset, req=8'hFF, grant_ready=1 held -> grant_idx sequence 0,1,2,...,7,0 on consecutive cycles.
REQ-030 Round-robin, req=8'b1000_0001, grant_ready=0 for 4 cycles, then 1 -> grant_idx=0 held stable for 4 cycles; next grant is idx 7, then idx 0.
REQ-031 HOLD with grant_idx=3, req drops to 0 with grant_ready=0 -> grant stays 8'b0000_1000; on grant_ready=1 the block returns to IDLE and all outputs become 0 on the next edge.
REQ-032 rst_n pulsed low mid-HOLD (grant_idx=6) between clock edges -> outputs become 0 asynchronously; after release with round-robin and req=8'hFF the first grant is idx 0.
REQ-033 Mode switched from 1 to 0 during HOLD (held idx 2, req=8'b1000_0100) -> idx 2 stays held until accepted; the next grant is idx 7 (fixed priority).
